// File: rtl/ice_uart_cmd_rx_pkg.sv
// Shared types and constants for the ICE UART command-frame receiver.
package ice_uart_cmd_rx_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 20000;
  localparam logic [7:0]  EID_UNKNOWN        = 8'hFF;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_BUSY     = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EID,
    S_LEN,
    S_PAYLOAD,
    S_DRAIN,
    S_DISCARD
  } state_t;

endpackage

// File: rtl/ice_uart_cmd_rx_byte_fifo.sv
// Synchronous 8-bit FIFO with flush; pointers carry one extra wrap bit for full/empty.
module ice_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ice_uart_cmd_rx.sv
// Host command frame receiver: [type, event_id, len, payload...] -> header handshake,
// buffered payload stream, and timeout/overflow/busy error reporting.
module ice_uart_cmd_rx
  import ice_uart_cmd_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TO_W           = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_latch,
  input  logic [7:0] rx_data,
  output logic       hdr_valid,
  input  logic       hdr_ready,
  output logic [7:0] hdr_type,
  output logic [7:0] hdr_event_id,
  output logic [7:0] hdr_len,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic [7:0] pl_data,
  output logic       pl_last,
  output logic       pl_abort,
  output logic       err_valid,
  output logic [1:0] err_code,
  output logic [7:0] err_event_id,
  output logic       busy
);

  state_t      state, state_nxt;
  err_code_t   err_det, err_code_q;
  logic        rx_latch_d;
  logic        byte_acc, byte_ok;
  logic [TO_W-1:0] to_cnt;
  logic        to_count_en, to_hit;
  logic [7:0]  rx_cnt, pop_cnt;
  logic        hdr_taken, eid_seen, busy_pend;
  logic        push, pop, flush, fifo_full, fifo_empty;

  assign byte_acc    = rx_latch && !rx_latch_d;
  assign to_count_en = state inside {S_EID, S_LEN, S_PAYLOAD, S_DISCARD};
  assign to_hit      = to_count_en && (to_cnt == TO_W'(TIMEOUT_CYCLES));
  // An expiring timeout swallows a byte edge that lands in the same cycle.
  assign byte_ok     = byte_acc && !to_hit;
  assign err_code    = err_code_q;

  ice_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (pl_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (byte_ok) state_nxt = S_EID;
      S_EID:     if (to_hit) state_nxt = S_IDLE;
                 else if (byte_ok) state_nxt = S_LEN;
      S_LEN:     if (to_hit) state_nxt = S_IDLE;
                 else if (byte_ok) state_nxt = (rx_data == '0) ? S_DRAIN : S_PAYLOAD;
      S_PAYLOAD: if (err_det == ERR_TIMEOUT) state_nxt = S_IDLE;
                 else if (err_det == ERR_OVERFLOW) state_nxt = S_DISCARD;
                 else if (push && rx_cnt == 8'd1) state_nxt = S_DRAIN;
      S_DRAIN:   if (hdr_taken && fifo_empty)
                   state_nxt = (busy_pend || byte_ok) ? S_DISCARD : S_IDLE;
      S_DISCARD: if (to_hit) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    err_det = ERR_NONE;
    push    = 1'b0;
    unique case (state)
      S_EID, S_LEN: if (to_hit) err_det = ERR_TIMEOUT;
      S_PAYLOAD: begin
        if (to_hit)                     err_det = ERR_TIMEOUT;
        else if (byte_acc && fifo_full) err_det = ERR_OVERFLOW;
        else                            push    = byte_acc;
      end
      S_DRAIN:   if (byte_acc) err_det = ERR_BUSY;
      default:   ;
    endcase
    flush    = (err_det == ERR_TIMEOUT) || (err_det == ERR_OVERFLOW);
    pl_valid = !fifo_empty && hdr_taken;
    pop      = pl_valid && pl_ready;
    pl_last  = pl_valid && (hdr_len != '0) && (pop_cnt == hdr_len - 8'd1);
    busy     = (state != S_IDLE) || hdr_valid || !fifo_empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_latch_d   <= 1'b0;
      to_cnt       <= '0;
      hdr_type     <= '0;
      hdr_event_id <= '0;
      hdr_len      <= '0;
      rx_cnt       <= '0;
      pop_cnt      <= '0;
      hdr_valid    <= 1'b0;
      hdr_taken    <= 1'b0;
      eid_seen     <= 1'b0;
      busy_pend    <= 1'b0;
      err_valid    <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_event_id <= '0;
      pl_abort     <= 1'b0;
    end else begin
      rx_latch_d <= rx_latch;
      to_cnt     <= (to_count_en && !byte_acc && !to_hit) ? to_cnt + TO_W'(1) : '0;
      err_valid  <= (err_det != ERR_NONE);
      pl_abort   <= flush;
      if (err_det != ERR_NONE) begin
        err_code_q   <= err_det;
        err_event_id <= (err_det != ERR_BUSY && eid_seen) ? hdr_event_id : EID_UNKNOWN;
      end
      if (byte_ok) begin
        case (state)
          S_IDLE: begin
            hdr_type <= rx_data;
            eid_seen <= 1'b0;
          end
          S_EID: begin
            hdr_event_id <= rx_data;
            eid_seen     <= 1'b1;
          end
          S_LEN: begin
            hdr_len   <= rx_data;
            rx_cnt    <= rx_data;
            hdr_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      if (push) rx_cnt  <= rx_cnt - 8'd1;
      if (pop)  pop_cnt <= pop_cnt + 8'd1;
      if (hdr_valid && hdr_ready) begin
        hdr_valid <= 1'b0;
        hdr_taken <= 1'b1;
      end
      if (state_nxt != S_DRAIN)      busy_pend <= 1'b0;
      else if (err_det == ERR_BUSY)  busy_pend <= 1'b1;
      // Frame bookkeeping is dropped whenever the frame ends, normally or by abort.
      if (flush || state_nxt inside {S_IDLE, S_DISCARD}) begin
        hdr_valid <= 1'b0;
        hdr_taken <= 1'b0;
        pop_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ice_uart_cmd_rx.sv
// Self-checking bench for ice_uart_cmd_rx: directed frame scenarios plus randomized frames.
module tb_ice_uart_cmd_rx;

  localparam int unsigned TO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_latch;
  logic [7:0] rx_data;
  logic       hdr_valid, hdr_ready;
  logic [7:0] hdr_type, hdr_event_id, hdr_len;
  logic       pl_valid, pl_ready, pl_last, pl_abort;
  logic [7:0] pl_data;
  logic       err_valid;
  logic [1:0] err_code;
  logic [7:0] err_event_id;
  logic       busy;

  always #5 clk = ~clk;

  ice_uart_cmd_rx #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (9)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_latch     (rx_latch),
    .rx_data      (rx_data),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .hdr_type     (hdr_type),
    .hdr_event_id (hdr_event_id),
    .hdr_len      (hdr_len),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .pl_data      (pl_data),
    .pl_last      (pl_last),
    .pl_abort     (pl_abort),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_event_id (err_event_id),
    .busy         (busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [23:0] obs_hdr[$];
  logic [8:0]  obs_pl[$];
  logic [9:0]  obs_err[$];
  int unsigned abort_cnt = 0;
  int unsigned clr_seq = 0;
  int unsigned clr_seen = 0;
  int unsigned hr_mode = 1;   // 0 low, 1 high, 2 random with bounded low runs
  int unsigned pr_mode = 1;

  always @(negedge clk) begin
    if (clr_seen != clr_seq) begin
      obs_hdr.delete();
      obs_pl.delete();
      obs_err.delete();
      abort_cnt = 0;
      clr_seen  = clr_seq;
    end
    if (hdr_valid && hdr_ready) obs_hdr.push_back({hdr_type, hdr_event_id, hdr_len});
    if (pl_valid && pl_ready)   obs_pl.push_back({pl_last, pl_data});
    if (err_valid)              obs_err.push_back({err_code, err_event_id});
    if (pl_abort)               abort_cnt++;
  end

  initial begin
    int unsigned hl = 0;
    int unsigned pll = 0;
    hdr_ready = 1'b0;
    pl_ready  = 1'b0;
    forever begin
      @(posedge clk); #1;
      hdr_ready = (hr_mode == 2) ? ((hl >= 3) || ($urandom_range(0, 1) == 1)) : (hr_mode == 1);
      pl_ready  = (pr_mode == 2) ? ((pll >= 3) || ($urandom_range(0, 1) == 1)) : (pr_mode == 1);
      hl  = hdr_ready ? 0 : hl + 1;
      pll = pl_ready ? 0 : pll + 1;
    end
  end

  initial begin
    #600_000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    clr_seq++;
    @(negedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned hold, input int unsigned gap);
    @(posedge clk); #1;
    rx_data  = b;
    rx_latch = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rx_latch = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // hold == 0 selects random strobe width and spacing
  task automatic send_frame(input logic [7:0] t, input logic [7:0] e, input logic [7:0] pl[$],
                            input int unsigned hold);
    logic [7:0] bytes[$];
    bytes.push_back(t);
    bytes.push_back(e);
    bytes.push_back(8'(pl.size()));
    foreach (pl[i]) bytes.push_back(pl[i]);
    foreach (bytes[i])
      send_byte(bytes[i], (hold == 0) ? $urandom_range(1, 3) : hold,
                (hold == 0) ? $urandom_range(8, 20) : 10);
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":idle"}, 32'(busy), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] t, input logic [7:0] e,
                              input logic [7:0] pl[$]);
    int unsigned n;
    check({tag, ":hdr_n"}, 32'(obs_hdr.size()), 32'd1);
    if (obs_hdr.size() > 0)
      check({tag, ":hdr"}, 32'(obs_hdr[0]), {8'h0, t, e, 8'(pl.size())});
    check({tag, ":pl_n"}, 32'(obs_pl.size()), 32'(pl.size()));
    n = (obs_pl.size() < pl.size()) ? obs_pl.size() : pl.size();
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("%s:pl%0d", tag, i), 32'(obs_pl[i]),
            {23'h0, (i == pl.size() - 1), pl[i]});
    check({tag, ":err_n"}, 32'(obs_err.size()), 32'd0);
    check({tag, ":abort"}, abort_cnt, 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] t, e;

    reset    = 1'b0;
    rx_latch = 1'b0;
    rx_data  = '0;
    #1;
    check("rst_hdr_valid", 32'(hdr_valid), 32'd0);
    check("rst_pl_valid", 32'(pl_valid), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_eid", 32'(err_event_id), 32'd0);
    check("rst_hdr_type", 32'(hdr_type), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    clear_obs();

    // Nominal 8-byte frame, both readies high
    pl = {8'hf0, 8'h12, 8'h34, 8'h50, 8'hde, 8'had, 8'hbe, 8'hef};
    send_frame(8'h62, 8'h0c, pl, 1);
    wait_idle("t1", 200);
    expect_frame("t1", 8'h62, 8'h0c, pl);

    // Dispatcher stalled: header and payload held until release
    clear_obs();
    hr_mode = 0;
    pr_mode = 0;
    pl = {8'h6d, 8'h01};
    send_frame(8'h6d, 8'h0f, pl, 1);
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("t2_hdr_held", 32'(hdr_valid), 32'd1);
    check("t2_hdr_fields", {8'h0, hdr_type, hdr_event_id, hdr_len}, 32'h006d0f02);
    check("t2_pl_gated", 32'(pl_valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    hr_mode = 1;
    pr_mode = 1;
    wait_idle("t2", 100);
    expect_frame("t2", 8'h6d, 8'h0f, pl);

    // Zero-length frame
    clear_obs();
    pl.delete();
    send_frame(8'h56, 8'h00, pl, 1);
    wait_idle("t3", 100);
    expect_frame("t3", 8'h56, 8'h00, pl);

    // Timeout mid-payload, then a clean frame
    clear_obs();
    send_byte(8'h62, 1, 10);
    send_byte(8'h0c, 1, 10);
    send_byte(8'h08, 1, 10);
    send_byte(8'hf0, 1, 10);
    send_byte(8'h12, 1, 10);
    wait_idle("t4", TO + 100);
    check("t4_err_n", 32'(obs_err.size()), 32'd1);
    if (obs_err.size() > 0) check("t4_err", 32'(obs_err[0]), 32'({2'd1, 8'h0c}));
    check("t4_abort", abort_cnt, 32'd1);
    check("t4_pl_n", 32'(obs_pl.size()), 32'd2);
    if (obs_pl.size() == 2) begin
      check("t4_pl0", 32'(obs_pl[0]), 32'h0f0);
      check("t4_pl1", 32'(obs_pl[1]), 32'h012);
    end
    clear_obs();
    pl = {8'h6d, 8'h01};
    send_frame(8'h6d, 8'h0d, pl, 1);
    wait_idle("t4b", 100);
    expect_frame("t4b", 8'h6d, 8'h0d, pl);

    // Timeout before the event id arrived
    clear_obs();
    send_byte(8'h62, 1, 10);
    wait_idle("t4c", TO + 100);
    check("t4c_err_n", 32'(obs_err.size()), 32'd1);
    if (obs_err.size() > 0) check("t4c_err", 32'(obs_err[0]), 32'({2'd1, 8'hff}));
    check("t4c_hdr_n", 32'(obs_hdr.size()), 32'd0);

    // Overflow of the 4-deep buffer on the 5th payload byte
    clear_obs();
    pr_mode = 0;
    send_byte(8'h62, 1, 10);
    send_byte(8'h14, 1, 10);
    send_byte(8'h08, 1, 10);
    for (int unsigned i = 0; i < 8; i++) send_byte(8'($urandom), 1, 10);
    @(negedge clk);
    check("t5_discard_busy", 32'(busy), 32'd1);
    wait_idle("t5", TO + 100);
    check("t5_err_n", 32'(obs_err.size()), 32'd1);
    if (obs_err.size() > 0) check("t5_err", 32'(obs_err[0]), 32'({2'd2, 8'h14}));
    check("t5_abort", abort_cnt, 32'd1);
    check("t5_pl_n", 32'(obs_pl.size()), 32'd0);
    pr_mode = 1;
    clear_obs();
    pl = {8'haa, 8'hbb, 8'hcc};
    send_frame(8'h6d, 8'h15, pl, 1);
    wait_idle("t5b", 100);
    expect_frame("t5b", 8'h6d, 8'h15, pl);

    // Byte arriving while draining: BUSY, draining frame intact
    clear_obs();
    hr_mode = 0;
    pl.delete();
    send_frame(8'h56, 8'h21, pl, 1);
    send_byte(8'h77, 1, 10);
    @(negedge clk);
    check("t6_hdr_held", 32'(hdr_valid), 32'd1);
    check("t6_hdr_eid", 32'(hdr_event_id), 32'h21);
    check("t6_err_n", 32'(obs_err.size()), 32'd1);
    if (obs_err.size() > 0) check("t6_err", 32'(obs_err[0]), 32'({2'd3, 8'hff}));
    hr_mode = 1;
    wait_idle("t6", TO + 100);
    check("t6_hdr_n", 32'(obs_hdr.size()), 32'd1);
    if (obs_hdr.size() > 0) check("t6_hdr", 32'(obs_hdr[0]), 32'h00562100);
    clear_obs();
    pl = {8'h01};
    send_frame(8'h62, 8'h22, pl, 1);
    wait_idle("t6b", 100);
    expect_frame("t6b", 8'h62, 8'h22, pl);

    // Asynchronous reset mid-payload, then frame with held strobes
    send_byte(8'h62, 1, 10);
    send_byte(8'h10, 1, 10);
    send_byte(8'h05, 1, 10);
    send_byte(8'h11, 1, 10);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("t7_hdr_valid", 32'(hdr_valid), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_hdr_len", 32'(hdr_len), 32'd0);
    check("t7_err_valid", 32'(err_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    clear_obs();
    pl = {8'hde, 8'had, 8'hbe};
    send_frame(8'h62, 8'h31, pl, 3);
    wait_idle("t7", 100);
    expect_frame("t7", 8'h62, 8'h31, pl);

    // Random frames with jittered readies
    hr_mode = 2;
    pr_mode = 2;
    for (int unsigned f = 0; f < 12; f++) begin
      clear_obs();
      t = 8'($urandom);
      e = 8'($urandom);
      pl.delete();
      repeat ($urandom_range(0, 10)) pl.push_back(8'($urandom));
      send_frame(t, e, pl, 0);
      wait_idle($sformatf("rnd%0d", f), 300);
      expect_frame($sformatf("rnd%0d", f), t, e, pl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
